// File: rtl/apb2sram_mbank.sv
// APB4 slave bridge fanning one APB port out to NBANK SRAM banks, with bank
// decode, write privilege check and per-access timeout.
module apb2sram_mbank #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int DOMAIN_W       = 1,
  parameter int MEM_ADDR_WIDTH = 11,
  parameter int NBANK          = 4,
  parameter int TIMEOUT        = 16,
  parameter int PRIV_WR_ONLY   = 1
) (
  input  logic                        gated_clk,
  input  logic                        prst_n_i,
  input  logic                        psel_i,
  input  logic                        penable_i,
  input  logic                        pwrite_i,
  input  logic [ADDR_WIDTH-1:0]       paddr_i,
  input  logic [DATA_WIDTH-1:0]       pwdata_i,
  input  logic [DATA_WIDTH/8-1:0]     pstrb_i,
  input  logic [2:0]                  pprot_i,
  input  logic [DOMAIN_W-1:0]         acc_did_i,
  output logic [DATA_WIDTH-1:0]       prdata_o,
  output logic                        pready_o,
  output logic                        pslverr_o,
  output logic                        clk_en_o,
  output logic [NBANK-1:0]            mem_csb_o,
  output logic                        mem_rwb_o,
  output logic [MEM_ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]       mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]     mem_wm_o,
  output logic [2:0]                  mem_prot_o,
  output logic [DOMAIN_W-1:0]         acc_did_o,
  input  logic [NBANK-1:0]            mem_rdy_i,
  input  logic [NBANK-1:0]            mem_err_i,
  input  logic [NBANK*DATA_WIDTH-1:0] mem_rdata_i,
  output logic                        timeout_evt_o
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int BOFF   = $clog2(STRB_W);
  localparam int BANK_W = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TLAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic                        wr_q, wr_d;
  logic [MEM_ADDR_WIDTH-1:0]   word_q, word_d;
  logic [BANK_W-1:0]           bank_q, bank_d;
  logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
  logic [STRB_W-1:0]           strb_q, strb_d;
  logic [2:0]                  prot_q, prot_d;
  logic [DOMAIN_W-1:0]         did_q, did_d;
  logic [CNT_W-1:0]            tcnt_q, tcnt_d;

  logic                        sel_rdy;
  logic                        sel_err;
  logic [DATA_WIDTH-1:0]       sel_rdata;
  logic                        bank_oob;
  logic                        priv_fail;
  logic                        reject;
  logic                        unused_paddr;

  // Only the word and bank fields of paddr are decoded here.
  assign unused_paddr = ^paddr_i;

  always_comb begin
    sel_rdy   = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int b = 0; b < NBANK; b++) begin
      if (bank_q == BANK_W'(b)) begin
        sel_rdy   = mem_rdy_i[b];
        sel_err   = mem_err_i[b];
        sel_rdata = mem_rdata_i[b*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bank_oob  = (32'(bank_q) >= 32'(NBANK));
  assign priv_fail = (PRIV_WR_ONLY != 0) && wr_q && !prot_q[0];
  assign reject    = bank_oob || priv_fail;

  // APB handshake: a transfer is taken in IDLE on psel & ~penable; the
  // response is valid only in the single cycle where pready_o is 1, and
  // pslverr_o/prdata_o are meaningful only in that cycle.
  always_comb begin
    state_d       = state_q;
    wr_d          = wr_q;
    word_d        = word_q;
    bank_d        = bank_q;
    wdata_d       = wdata_q;
    strb_d        = strb_q;
    prot_d        = prot_q;
    did_d         = did_q;
    tcnt_d        = tcnt_q;
    mem_csb_o     = '1;
    pready_o      = 1'b0;
    pslverr_o     = 1'b0;
    prdata_o      = '0;
    timeout_evt_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (psel_i && !penable_i) begin
          wr_d    = pwrite_i;
          word_d  = paddr_i[BOFF +: MEM_ADDR_WIDTH];
          bank_d  = paddr_i[BOFF+MEM_ADDR_WIDTH +: BANK_W];
          wdata_d = pwdata_i;
          strb_d  = pwrite_i ? pstrb_i : '0;
          prot_d  = pprot_i;
          did_d   = acc_did_i;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (penable_i) begin
          if (reject) begin
            pready_o  = 1'b1;
            pslverr_o = 1'b1;
            state_d   = S_IDLE;
          end else begin
            mem_csb_o = ~(NBANK'(1) << bank_q);
            tcnt_d    = '0;
            state_d   = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // rdy takes priority over a timeout landing on the same cycle.
        if (sel_rdy) begin
          pready_o  = 1'b1;
          pslverr_o = sel_err;
          if (!wr_q && !sel_err) prdata_o = sel_rdata;
          state_d   = S_IDLE;
        end else if ((TIMEOUT != 0) && (tcnt_q == TLAST)) begin
          pready_o      = 1'b1;
          pslverr_o     = 1'b1;
          timeout_evt_o = 1'b1;
          state_d       = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge gated_clk or negedge prst_n_i) begin
    if (!prst_n_i) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      word_q  <= '0;
      bank_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      prot_q  <= '0;
      did_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      word_q  <= word_d;
      bank_q  <= bank_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      prot_q  <= prot_d;
      did_q   <= did_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign clk_en_o    = (state_q != S_IDLE) || psel_i;
  assign mem_rwb_o   = wr_q;
  assign mem_addr_o  = word_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wm_o    = strb_q;
  assign mem_prot_o  = prot_q;
  assign acc_did_o   = did_q;

endmodule

// File: tb/tb_apb2sram_mbank.sv
// Bench for apb2sram_mbank: a 4-bank and a 3-bank instance share one APB
// master; responses are checked against a word-level reference memory.
module tb_apb2sram_mbank;

  localparam int TIMEOUT = 16;

  logic         gated_clk = 1'b0;
  logic         prst_n_i;
  logic         psel, penable, pwrite;
  logic [31:0]  paddr, pwdata;
  logic [3:0]   pstrb;
  logic [2:0]   pprot;
  logic [0:0]   did;
  logic [3:0]   mem_rdy, mem_err;
  logic [127:0] mem_rdata;

  logic [31:0]  prdata;
  logic         pready, pslverr, clk_en, rwb, tevt;
  logic [3:0]   csb, wm;
  logic [10:0]  maddr;
  logic [31:0]  mwdata;
  logic [2:0]   mprot;
  logic [0:0]   mdid;

  logic [31:0]  prdata3;
  logic         pready3, pslverr3, clk_en3, rwb3, tevt3;
  logic [2:0]   csb3;
  logic [3:0]   wm3;
  logic [10:0]  maddr3;
  logic [31:0]  mwdata3;
  logic [2:0]   mprot3;
  logic [0:0]   mdid3;

  int checks = 0;
  int errors = 0;

  logic [31:0] sram_mem[int];
  logic [31:0] ref_mem[int];

  apb2sram_mbank #(.NBANK(4), .TIMEOUT(TIMEOUT)) u_dut (
    .gated_clk(gated_clk), .prst_n_i(prst_n_i),
    .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb), .pprot_i(pprot),
    .acc_did_i(did), .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
    .clk_en_o(clk_en), .mem_csb_o(csb), .mem_rwb_o(rwb), .mem_addr_o(maddr),
    .mem_wdata_o(mwdata), .mem_wm_o(wm), .mem_prot_o(mprot), .acc_did_o(mdid),
    .mem_rdy_i(mem_rdy), .mem_err_i(mem_err), .mem_rdata_i(mem_rdata),
    .timeout_evt_o(tevt)
  );

  apb2sram_mbank #(.NBANK(3), .TIMEOUT(TIMEOUT)) u_dut3 (
    .gated_clk(gated_clk), .prst_n_i(prst_n_i),
    .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb), .pprot_i(pprot),
    .acc_did_i(did), .prdata_o(prdata3), .pready_o(pready3), .pslverr_o(pslverr3),
    .clk_en_o(clk_en3), .mem_csb_o(csb3), .mem_rwb_o(rwb3), .mem_addr_o(maddr3),
    .mem_wdata_o(mwdata3), .mem_wm_o(wm3), .mem_prot_o(mprot3), .acc_did_o(mdid3),
    .mem_rdy_i(mem_rdy[2:0]), .mem_err_i(mem_err[2:0]), .mem_rdata_i(mem_rdata[95:0]),
    .timeout_evt_o(tevt3)
  );

  // Clock / reset
  always #5 gated_clk = ~gated_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge gated_clk);
    #1;
  endtask

  function automatic int key(int bank, int word);
    return bank * 4096 + word;
  endfunction

  function automatic logic [31:0] ref_rd(int k);
    return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
  endfunction

  function automatic logic [31:0] sram_rd(int k);
    return sram_mem.exists(k) ? sram_mem[k] : 32'h0;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] m);
    logic [31:0] v;
    v = old;
    for (int i = 0; i < 4; i++) if (m[i]) v[8*i +: 8] = d[8*i +: 8];
    return v;
  endfunction

  task automatic preload(int bank, int word, logic [31:0] v);
    sram_mem[key(bank, word)] = v;
    ref_mem[key(bank, word)]  = v;
  endtask

  task automatic go_idle(int n);
    psel = 1'b0;
    penable = 1'b0;
    repeat (n) step();
  endtask

  // Driver: one full APB transfer. delay = WAIT cycles before rdy, -1 = never.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [2:0] prot,
                          input int delay, input logic err);
    int bank, word, k;
    logic rej4, rej3, rdy_now, tmo_now;
    logic [3:0] exp_csb;
    logic [2:0] exp_csb3;
    logic [3:0] exp_wm;
    bank = int'((addr >> 13) & 32'h3);
    word = int'((addr >> 2) & 32'h7FF);
    k    = key(bank, word);
    rej4 = wr && !prot[0];
    rej3 = rej4 || (bank >= 3);
    exp_csb  = rej4 ? 4'hF : ~(4'b0001 << bank);
    exp_csb3 = rej3 ? 3'h7 : ~(3'b001 << bank);
    exp_wm   = wr ? strb : 4'h0;

    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    pstrb = strb; pprot = prot; did = 1'($urandom);
    mem_rdy = '0; mem_err = '0;
    @(negedge gated_clk);
    chk("setup_pready", pready, 0);
    chk("setup_csb", csb, 4'hF);
    chk("setup_clk_en", clk_en, 1);
    step();

    penable = 1'b1;
    @(negedge gated_clk);
    chk("acc_pready", pready, rej4);
    chk("acc_pslverr", pslverr, rej4);
    chk("acc_csb", csb, exp_csb);
    chk("acc_csb3", csb3, exp_csb3);
    chk("acc_pready3", pready3, rej3);
    chk("acc_pslverr3", pslverr3, rej3);
    chk("acc_addr", maddr, word);
    chk("acc_rwb", rwb, wr);
    chk("acc_wm", wm, exp_wm);
    chk("acc_prot", mprot, prot);
    chk("acc_did", mdid, did);
    if (wr) chk("acc_wdata", mwdata, wdata);
    if (!rej4 && wr) begin
      sram_mem[key(bank, int'(maddr))] = merge(sram_rd(key(bank, int'(maddr))), mwdata, wm);
      ref_mem[k] = merge(ref_rd(k), wdata, strb);
    end
    step();
    if (rej4) return;

    for (int w = 0; w < TIMEOUT + 2; w++) begin
      rdy_now = (w == delay);
      tmo_now = !rdy_now && (w == TIMEOUT - 1);
      mem_rdy = 4'($urandom);
      mem_err = 4'($urandom);
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      mem_rdy[bank] = rdy_now;
      if (rdy_now) mem_err[bank] = err;
      mem_rdata[bank*32 +: 32] = sram_rd(k);
      @(negedge gated_clk);
      chk("wait_pready", pready, rdy_now || tmo_now);
      chk("wait_pslverr", pslverr, tmo_now || (rdy_now && err));
      chk("wait_tevt", tevt, tmo_now);
      chk("wait_csb", csb, 4'hF);
      chk("wait_addr", maddr, word);
      chk("wait_clk_en", clk_en, 1);
      if (tmo_now || !rdy_now || wr) chk("wait_prdata0", prdata, 0);
      else if (!err) chk("rd_data", prdata, ref_rd(k));
      if (!rej3) chk("wait_pready3", pready3, rdy_now || tmo_now);
      step();
      if (rdy_now || tmo_now) break;
    end
    mem_rdy = '0;
    mem_err = '0;
  endtask

  initial begin
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          bank, word, delay;
    logic        err;

    prst_n_i = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    pstrb = '0; pprot = '0; did = '0;
    mem_rdy = '0; mem_err = '0; mem_rdata = '0;
    repeat (2) @(posedge gated_clk);
    @(negedge gated_clk);
    chk("rst_csb", csb, 4'hF);
    chk("rst_csb3", csb3, 3'h7);
    chk("rst_pready", pready, 0);
    chk("rst_pslverr", pslverr, 0);
    chk("rst_prdata", prdata, 0);
    chk("rst_tevt", tevt, 0);
    chk("rst_clk_en", clk_en, 0);
    chk("rst_addr", maddr, 0);
    chk("rst_wm", wm, 0);
    step();
    prst_n_i = 1'b1;
    step();

    // Write to bank 1 word 2, rdy in the second WAIT cycle
    apb_xfer(1'b1, 32'h0000_2008, 32'hA5A5_1234, 4'hF, 3'b001, 1, 1'b0);
    go_idle(1);
    // Read back
    apb_xfer(1'b0, 32'h0000_2008, 32'h0, 4'hF, 3'b001, 0, 1'b0);

    // Read bank 3 word 0x7FF; 3-bank instance rejects it
    preload(3, 11'h7FF, 32'hDEAD_BEEF);
    apb_xfer(1'b0, 32'h0000_7FFC, 32'h0, 4'hF, 3'b001, 0, 1'b0);
    apb_xfer(1'b0, 32'hFFFF_6004, 32'h0, 4'h0, 3'b011, 2, 1'b0);
    go_idle(2);

    // Unprivileged write rejected, same access as a read completes
    apb_xfer(1'b1, 32'h0000_200C, 32'h1111_2222, 4'hF, 3'b000, 0, 1'b0);
    apb_xfer(1'b0, 32'h0000_200C, 32'h0, 4'h0, 3'b000, 0, 1'b0);
    // Zero-strobe write still issued and leaves the word unchanged
    apb_xfer(1'b1, 32'h0000_2008, 32'hFFFF_FFFF, 4'h0, 3'b001, 0, 1'b0);
    apb_xfer(1'b0, 32'h0000_2008, 32'h0, 4'h0, 3'b001, 0, 1'b0);
    go_idle(1);

    // Timeout, late rdy ignored, then a normal transfer
    apb_xfer(1'b0, 32'h0000_0010, 32'h0, 4'h0, 3'b001, -1, 1'b0);
    go_idle(1);
    mem_rdy[0] = 1'b1;
    mem_err[0] = 1'b1;
    @(negedge gated_clk);
    chk("late_rdy_pready", pready, 0);
    chk("late_rdy_pslverr", pslverr, 0);
    chk("late_rdy_tevt", tevt, 0);
    chk("late_rdy_clk_en", clk_en, 0);
    step();
    mem_rdy = '0; mem_err = '0;
    apb_xfer(1'b1, 32'h0000_0010, 32'h0BAD_F00D, 4'b0101, 3'b001, 0, 1'b0);
    apb_xfer(1'b0, 32'h0000_0010, 32'h0, 4'h0, 3'b001, 3, 1'b0);
    go_idle(1);

    // Reset asserted in WAIT
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0000_4014; pprot = 3'b001;
    step();
    penable = 1'b1;
    step();
    @(negedge gated_clk);
    prst_n_i = 1'b0;
    #1;
    chk("mid_rst_csb", csb, 4'hF);
    chk("mid_rst_pready", pready, 0);
    chk("mid_rst_pslverr", pslverr, 0);
    chk("mid_rst_prdata", prdata, 0);
    chk("mid_rst_tevt", tevt, 0);
    chk("mid_rst_clk_en_psel", clk_en, 1);
    psel = 1'b0; penable = 1'b0;
    #1;
    chk("mid_rst_clk_en_idle", clk_en, 0);
    mem_rdy[2] = 1'b1;
    step();
    prst_n_i = 1'b1;
    @(negedge gated_clk);
    chk("post_rst_rdy_ignored", pready, 0);
    chk("post_rst_clk_en", clk_en, 0);
    step();
    mem_rdy = '0;
    apb_xfer(1'b0, 32'h0000_4014, 32'h0, 4'h0, 3'b001, 0, 1'b0);
    apb_xfer(1'b1, 32'h0000_0004, 32'h7654_3210, 4'hF, 3'b001, 0, 1'b0);
    apb_xfer(1'b0, 32'h0000_0004, 32'h0, 4'h0, 3'b001, 1, 1'b0);
    go_idle(1);

    // Randomized traffic against the reference memory
    for (int i = 0; i < 60; i++) begin
      bank = $urandom_range(0, 3);
      word = $urandom_range(0, 7);
      addr = {17'($urandom), 2'(bank), 11'(word), 2'($urandom)};
      wr   = 1'($urandom_range(0, 1));
      strb = 4'($urandom);
      prot = 3'($urandom);
      if ($urandom_range(0, 3) != 0) prot[0] = 1'b1;
      delay = ($urandom_range(0, 11) == 0) ? -1 : $urandom_range(0, 4);
      err   = ($urandom_range(0, 7) == 0);
      apb_xfer(wr, addr, 32'($urandom), strb, prot, delay, err);
      if ($urandom_range(0, 1) == 1) go_idle($urandom_range(1, 3));
    end
    go_idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
